// File: rtl/pc_gen_ras.sv
// Fetch PC generator with a circular return-address stack for IF-stage ret prediction.
// Define PC_RAS_EN to build the RAS and the IF_RAS next-PC source; without it code 4 behaves as SEQ.
module pc_gen_ras #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                FETCH_BYTES = 4,
    parameter int                RAS_DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hcf,
    input  logic                           stall,
    input  logic [2:0]                     pc_sel,
    input  logic [ADDR_W-1:0]              pred_target,
    input  logic [ADDR_W-1:0]              exe_target,
    input  logic [ADDR_W-1:0]              exe_pc,
    input  logic                           ras_push,
    input  logic                           ras_pop,
    input  logic                           ras_clear,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              ras_top,
    output logic                           ras_valid,
    output logic [$clog2(RAS_DEPTH):0]     ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_SEQ     = 3'd0;
    localparam logic [2:0] SEL_IF_P_T  = 3'd1;
    localparam logic [2:0] SEL_EXE_PC4 = 3'd2;
    localparam logic [2:0] SEL_EXE_T   = 3'd3;
    localparam logic [2:0] SEL_IF_RAS  = 3'd4;

    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] exe_plus4;
    logic [ADDR_W-1:0] pc_next;
    logic              hold;

    assign pc_plus   = pc + ADDR_W'(FETCH_BYTES);
    assign exe_plus4 = exe_pc + ADDR_W'(4);
    assign hold      = hcf | stall;

`ifdef PC_RAS_EN
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [CNT_W-1:0]  cnt;
    logic [PTR_W-1:0]  top_idx;

    // Occupancy saturates at the depth; extra pushes overwrite the oldest entry.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    assign top_idx   = wp - PTR_W'(1);
    assign ras_valid = (cnt != '0);
    assign ras_top   = ras_valid ? ras_mem[top_idx] : '0;
    assign ras_count = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (!hcf) begin
            // Clear wins over stall so the hazard unit can flush during a stalled cycle.
            if (ras_clear) begin
                wp  <= '0;
                cnt <= '0;
            end else if (!stall) begin
                if (ras_push && ras_pop && ras_valid) begin
                    ras_mem[top_idx] <= pc_plus;
                end else if (ras_push) begin
                    ras_mem[wp] <= pc_plus;
                    wp          <= wp + PTR_W'(1);
                    cnt         <= sat_inc(cnt);
                end else if (ras_pop && ras_valid) begin
                    wp  <= top_idx;
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_clear};
    assign ras_top    = '0;
    assign ras_valid  = 1'b0;
    assign ras_count  = '0;
`endif

    always_comb begin
        pc_next = pc_plus;
        case (pc_sel)
            SEL_SEQ:     pc_next = pc_plus;
            SEL_IF_P_T:  pc_next = pred_target;
            SEL_EXE_PC4: pc_next = exe_plus4;
            SEL_EXE_T:   pc_next = exe_target;
`ifdef PC_RAS_EN
            SEL_IF_RAS:  pc_next = ras_valid ? ras_top : pc_plus;
`endif
            default:     pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!hold) begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras (RESET_PC=0x100, RAS_DEPTH=4); expectations follow PC_RAS_EN.
module tb_pc_gen_ras;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hcf = 1'b0, stall = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [31:0] pred_target = '0, exe_target = '0, exe_pc = '0;
    logic        ras_push = 1'b0, ras_pop = 1'b0, ras_clear = 1'b0;
    logic [31:0] pc, ras_top;
    logic        ras_valid;
    logic [2:0]  ras_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] tgt;
        logic        push, pop, clr, st, h;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_top;
    } step_t;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic [31:0] top;
    } exp_t;

    exp_t exp_q[$];

    pc_gen_ras #(
        .ADDR_W(32), .RESET_PC(32'h100), .FETCH_BYTES(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .hcf(hcf), .stall(stall), .pc_sel(pc_sel),
        .pred_target(pred_target), .exe_target(exe_target), .exe_pc(exe_pc),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_clear(ras_clear),
        .pc(pc), .ras_top(ras_top), .ras_valid(ras_valid), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic [2:0] sel, input logic [31:0] tgt,
                                 input logic push, input logic pop, input logic clr,
                                 input logic st, input logic h, input logic [31:0] e_pc,
                                 input logic [2:0] e_cnt, input logic [31:0] e_top);
        step_t s;
        s.sel = sel; s.tgt = tgt; s.push = push; s.pop = pop; s.clr = clr;
        s.st = st; s.h = h; s.e_pc = e_pc; s.e_cnt = e_cnt; s.e_top = e_top;
        return s;
    endfunction

    function automatic logic [2:0] rc(input int c);
        return RAS_ON ? 3'(c) : 3'd0;
    endfunction

    function automatic logic [31:0] rt(input logic [31:0] v);
        return RAS_ON ? v : 32'd0;
    endfunction

    function automatic logic [31:0] rp(input logic [31:0] on_v, input logic [31:0] off_v);
        return RAS_ON ? on_v : off_v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of stimulus and queues what the DUT must show after the edge.
    task automatic apply(input step_t s);
        pc_sel = s.sel; pred_target = s.tgt; exe_target = s.tgt; exe_pc = s.tgt;
        ras_push = s.push; ras_pop = s.pop; ras_clear = s.clr; stall = s.st; hcf = s.h;
        exp_q.push_back('{pc: s.e_pc, cnt: s.e_cnt, top: s.e_top});
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", ras_count); end
        n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ras_valid); end
        n_tests++; if (ras_top !== 32'd0) begin n_fail++; $display("FAIL reset_top got %h want 0", ras_top); end
        rst = 1'b0;
    endtask

    task automatic run_table(input string name, input step_t q[$]);
        exp_t e;
        foreach (q[i]) begin
            apply(q[i]);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc) begin n_fail++; $display("FAIL %s[%0d] pc got %h want %h", name, i, pc, e.pc); end
            n_tests++;
            if (ras_count !== e.cnt) begin n_fail++; $display("FAIL %s[%0d] ras_count got %0d want %0d", name, i, ras_count, e.cnt); end
            n_tests++;
            if (ras_valid !== (e.cnt != 0)) begin n_fail++; $display("FAIL %s[%0d] ras_valid got %b want %b", name, i, ras_valid, e.cnt != 0); end
            n_tests++;
            if (ras_top !== e.top) begin n_fail++; $display("FAIL %s[%0d] ras_top got %h want %h", name, i, ras_top, e.top); end
        end
    endtask

    task automatic test_seq();
        step_t q[$];
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h108, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h10C, 0, 0));
        run_table("seq", q);
    endtask

    task automatic test_hold_and_sel();
        step_t q[$];
        q.push_back(mk(3, 32'h400,  0, 0, 0, 1, 0, 32'h10C, 0, 0));
        q.push_back(mk(3, 32'h400,  0, 0, 0, 0, 0, 32'h400, 0, 0));
        q.push_back(mk(1, 32'h999,  0, 0, 0, 0, 1, 32'h400, 0, 0));
        q.push_back(mk(1, 32'h40,   0, 0, 0, 0, 0, 32'h40,  0, 0));
        q.push_back(mk(2, 32'h70,   0, 0, 0, 0, 0, 32'h74,  0, 0));
        q.push_back(mk(5, 32'h999,  0, 0, 0, 0, 0, 32'h78,  0, 0));
        q.push_back(mk(6, 32'h999,  0, 0, 0, 0, 0, 32'h7C,  0, 0));
        q.push_back(mk(7, 32'h999,  0, 0, 0, 0, 0, 32'h80,  0, 0));
        q.push_back(mk(3, 32'h1234, 0, 0, 0, 1, 1, 32'h80,  0, 0));
        run_table("hold", q);
    endtask

    task automatic test_ras_push_pop();
        step_t q[$];
        q.push_back(mk(1, 32'h10,  0, 0, 0, 0, 0, 32'h10,  0, 0));
        q.push_back(mk(1, 32'h20,  1, 0, 0, 0, 0, 32'h20,  rc(1), rt(32'h14)));
        q.push_back(mk(1, 32'h30,  1, 0, 0, 0, 0, 32'h30,  rc(2), rt(32'h24)));
        q.push_back(mk(1, 32'h500, 1, 0, 0, 0, 0, 32'h500, rc(3), rt(32'h34)));
        q.push_back(mk(0, 0,       0, 0, 1, 0, 1, 32'h500, rc(3), rt(32'h34)));
        q.push_back(mk(4, 0,       0, 1, 0, 1, 0, 32'h500, rc(3), rt(32'h34)));
        q.push_back(mk(4, 0,       0, 1, 0, 0, 0, rp(32'h34, 32'h504), rc(2), rt(32'h24)));
        q.push_back(mk(4, 0,       0, 1, 0, 0, 0, rp(32'h24, 32'h508), rc(1), rt(32'h14)));
        q.push_back(mk(4, 0,       0, 1, 0, 0, 0, rp(32'h14, 32'h50C), 0, 0));
        run_table("ras", q);
    endtask

    task automatic test_overflow();
        step_t q[$];
        q.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0, 32'h1000, 0, 0));
        q.push_back(mk(1, 32'h2000, 1, 0, 0, 0, 0, 32'h2000, rc(1), rt(32'h1004)));
        q.push_back(mk(1, 32'h3000, 1, 0, 0, 0, 0, 32'h3000, rc(2), rt(32'h2004)));
        q.push_back(mk(1, 32'h4000, 1, 0, 0, 0, 0, 32'h4000, rc(3), rt(32'h3004)));
        q.push_back(mk(1, 32'h5000, 1, 0, 0, 0, 0, 32'h5000, rc(4), rt(32'h4004)));
        q.push_back(mk(1, 32'h6000, 1, 0, 0, 0, 0, 32'h6000, rc(4), rt(32'h5004)));
        q.push_back(mk(4, 0, 0, 1, 0, 0, 0, rp(32'h5004, 32'h6004), rc(3), rt(32'h4004)));
        q.push_back(mk(4, 0, 0, 1, 0, 0, 0, rp(32'h4004, 32'h6008), rc(2), rt(32'h3004)));
        q.push_back(mk(4, 0, 0, 1, 0, 0, 0, rp(32'h3004, 32'h600C), rc(1), rt(32'h2004)));
        q.push_back(mk(4, 0, 0, 1, 0, 0, 0, rp(32'h2004, 32'h6010), 0, 0));
        q.push_back(mk(4, 0, 0, 1, 0, 0, 0, rp(32'h2008, 32'h6014), 0, 0));
        run_table("overflow", q);
    endtask

    task automatic test_clear();
        step_t q[$];
        q.push_back(mk(1, 32'h600, 0, 0, 0, 0, 0, 32'h600, 0, 0));
        q.push_back(mk(1, 32'h700, 1, 0, 0, 0, 0, 32'h700, rc(1), rt(32'h604)));
        q.push_back(mk(1, 32'h800, 1, 0, 0, 0, 0, 32'h800, rc(2), rt(32'h704)));
        q.push_back(mk(3, 32'h900, 1, 1, 1, 1, 0, 32'h800, 0, 0));
        q.push_back(mk(0, 0,       1, 0, 1, 0, 0, 32'h804, 0, 0));
        run_table("clear", q);
    endtask

    task automatic test_back_to_back();
        step_t q[$];
        q.push_back(mk(1, 32'h7C,  0, 0, 0, 0, 0, 32'h7C,  0, 0));
        q.push_back(mk(1, 32'h200, 1, 0, 0, 0, 0, 32'h200, rc(1), rt(32'h80)));
        q.push_back(mk(4, 0,       1, 1, 0, 0, 0, rp(32'h80, 32'h204), rc(1), rt(32'h204)));
        q.push_back(mk(4, 0,       0, 1, 0, 0, 0, rp(32'h204, 32'h208), 0, 0));
        q.push_back(mk(0, 0,       1, 1, 0, 0, 0, rp(32'h208, 32'h20C), rc(1), rt(32'h208)));
        run_table("pushpop", q);
    endtask

    task automatic test_wrap();
        step_t q[$];
        q.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, rc(1), rt(32'h208)));
        q.push_back(mk(0, 0,             0, 0, 0, 0, 0, 32'h0,         rc(1), rt(32'h208)));
        q.push_back(mk(2, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 32'h2,         rc(1), rt(32'h208)));
        run_table("wrap", q);
    endtask

    task automatic test_reset_midrun();
        step_t q[$];
        q.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 1, 32'h2, rc(1), rt(32'h208)));
        run_table("prereset", q);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL async_rst_pc got %h want %h", pc, 32'h100); end
        n_tests++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL async_rst_cnt got %0d want 0", ras_count); end
        n_tests++; if (ras_top !== 32'd0) begin n_fail++; $display("FAIL async_rst_top got %h want 0", ras_top); end
        tick();
        rst = 1'b0;
        q.delete();
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0));
        run_table("postreset", q);
    endtask

    initial begin
        test_reset();
        test_seq();
        test_hold_and_sel();
        test_ras_push_pop();
        test_overflow();
        test_clear();
        test_back_to_back();
        test_wrap();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
